// File: rtl/fb_pkg.sv
// Shared types, defaults and pixel helpers for the double-buffered frame store.
package fb_pkg;

    localparam int FB_PIXEL_WIDTH   = 16;
    localparam int FB_SCREEN_W      = 320;
    localparam int FB_SCREEN_H      = 180;
    localparam int FB_SCALE_SHIFT   = 2;
    localparam int FB_FULL_W        = 1280;
    localparam int FB_FULL_H        = 720;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    typedef enum logic [0:0] {
        FILL = ST_FILL,
        DONE = ST_DONE
    } fb_state_t;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: single-port read-first RAM with a two-stage read pipe.
// The port is owned by the writer while this bank is the back buffer.
module fb_bank
    import fb_pkg::*;
#(
    parameter int PIXEL_WIDTH = FB_PIXEL_WIDTH,
    parameter int DEPTH       = FB_SCREEN_W * FB_SCREEN_H,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   is_back,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [PIXEL_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [PIXEL_WIDTH-1:0] rd_data
);

    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [PIXEL_WIDTH-1:0] ram_q;
    logic [PIXEL_WIDTH-1:0] rd_data_q;
    logic [ADDR_W-1:0]      addr;
    logic                   we;

    // Out-of-range writes are accepted upstream but never reach the array.
    always_comb begin
        addr = is_back ? wr_addr : rd_addr;
        we   = is_back && wr_en && (32'(wr_addr) < 32'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        ram_q     <= mem[addr];
        rd_data_q <= ram_q;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buffer_dual.sv
// Double-buffered frame store: writer fills the back bank, display reads the
// front bank upscaled; banks exchange only at a video frame boundary.
module frame_buffer_dual
    import fb_pkg::*;
#(
    parameter int          PIXEL_WIDTH        = FB_PIXEL_WIDTH,
    parameter int          SCREEN_WIDTH       = FB_SCREEN_W,
    parameter int          SCREEN_HEIGHT      = FB_SCREEN_H,
    parameter int          SCALE_SHIFT        = FB_SCALE_SHIFT,
    parameter int          FULL_SCREEN_WIDTH  = FB_FULL_W,
    parameter int          FULL_SCREEN_HEIGHT = FB_FULL_H,
    parameter logic [23:0] BG_COLOR           = 24'h000000,
    parameter int          ADDR_W             = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_pixel_in,
    input  logic                   wr_valid_in,
    input  logic [ADDR_W-1:0]      wr_addr_in,
    input  logic [PIXEL_WIDTH-1:0] wr_pixel_in,
    input  logic                   wr_last_in,
    output logic                   wr_ready_out,
    output logic [23:0]            rgb_out,
    output logic                   rgb_valid_out,
    output logic                   swap_out,
    output logic [7:0]             repeat_count_out
);

    if (FULL_SCREEN_WIDTH != (SCREEN_WIDTH << SCALE_SHIFT)) begin : g_bad_w
        $error("FULL_SCREEN_WIDTH must equal SCREEN_WIDTH << SCALE_SHIFT");
    end
    if (FULL_SCREEN_HEIGHT != (SCREEN_HEIGHT << SCALE_SHIFT)) begin : g_bad_h
        $error("FULL_SCREEN_HEIGHT must equal SCREEN_HEIGHT << SCALE_SHIFT");
    end

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    fb_state_t  state_q, state_d;
    logic       front_sel_q, front_sel_d;
    logic       swap_q, swap_d;
    logic [7:0] repeat_q, repeat_d;
    logic [1:0] sel_pipe_q, sel_pipe_d;
    logic [1:0] act_pipe_q, act_pipe_d;
    logic [23:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;

    logic              wr_fire;
    logic              last_fire;
    logic              active;
    logic [ADDR_W-1:0] rd_addr;
    logic              back0, back1;

    logic [PIXEL_WIDTH-1:0] rd_data0, rd_data1, pix_sel;
    logic [23:0]            pix_rgb;

    assign wr_ready_out = (state_q == FILL);

    always_comb begin
        wr_fire   = wr_valid_in && wr_ready_out;
        last_fire = wr_fire && wr_last_in;
        swap_d    = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            FILL: begin
                if (last_fire) begin
                    if (video_last_pixel_in) begin
                        swap_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (video_last_pixel_in) begin
                    swap_d  = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        front_sel_d = front_sel_q ^ swap_d;

        repeat_d = repeat_q;
        if (swap_d) begin
            repeat_d = '0;
        end else if (state_q == FILL && video_last_pixel_in
                     && repeat_q != 8'hFF) begin
            repeat_d = repeat_q + 8'd1;
        end
    end

    always_comb begin
        active = (hcount_in < 11'(FULL_SCREEN_WIDTH))
              && (vcount_in < 10'(FULL_SCREEN_HEIGHT));
        rd_addr = '0;
        if (active) begin
            rd_addr = ADDR_W'(vcount_in >> SCALE_SHIFT) * ADDR_W'(SCREEN_WIDTH)
                    + ADDR_W'(hcount_in >> SCALE_SHIFT);
        end
    end

    // front_sel=0 displays bank 1, so bank 0 is the back buffer.
    assign back0 = ~front_sel_q;
    assign back1 = front_sel_q;

    fb_bank #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DEPTH       (SCREEN_WIDTH * SCREEN_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_bank0 (
        .clk     (pixel_clk_in),
        .is_back (back0),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr_in),
        .wr_data (wr_pixel_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    fb_bank #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DEPTH       (SCREEN_WIDTH * SCREEN_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_bank1 (
        .clk     (pixel_clk_in),
        .is_back (back1),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr_in),
        .wr_data (wr_pixel_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    // The select travels with the read so in-flight pixels survive a swap.
    assign pix_sel = sel_pipe_q[1] ? rd_data0 : rd_data1;

    if (PIXEL_WIDTH == 16) begin : g_565
        assign pix_rgb = rgb565_to_888(pix_sel);
    end else if (PIXEL_WIDTH == 24) begin : g_888
        assign pix_rgb = pix_sel;
    end else begin : g_bad_pw
        $error("PIXEL_WIDTH must be 16 or 24");
    end

    always_comb begin
        sel_pipe_d  = {sel_pipe_q[0], front_sel_q};
        act_pipe_d  = {act_pipe_q[0], active};
        rgb_valid_d = act_pipe_q[1];
        rgb_d       = act_pipe_q[1] ? pix_rgb : BG_COLOR;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            front_sel_q <= 1'b0;
            swap_q      <= 1'b0;
            repeat_q    <= '0;
            sel_pipe_q  <= '0;
            act_pipe_q  <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_q      <= swap_d;
            repeat_q    <= repeat_d;
            sel_pipe_q  <= sel_pipe_d;
            act_pipe_q  <= act_pipe_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign rgb_out          = rgb_q;
    assign rgb_valid_out    = rgb_valid_q;
    assign swap_out         = swap_q;
    assign repeat_count_out = repeat_q;

endmodule

// File: tb/tb_frame_buffer_dual.sv
// Self-checking bench for frame_buffer_dual: behavioural model plus
// hand-computed readback table and directed corner sequences.
module tb_frame_buffer_dual;

    localparam int W = 320;
    localparam int H = 180;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        vlast;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_pix;
    logic        wr_last;
    logic        wr_ready;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic        swap_out;
    logic [7:0]  rep_out;

    always #5 clk = ~clk;

    frame_buffer_dual dut (
        .pixel_clk_in        (clk),
        .rst_n_in            (rst_n),
        .hcount_in           (hc),
        .vcount_in           (vc),
        .video_last_pixel_in (vlast),
        .wr_valid_in         (wr_valid),
        .wr_addr_in          (wr_addr),
        .wr_pixel_in         (wr_pix),
        .wr_last_in          (wr_last),
        .wr_ready_out        (wr_ready),
        .rgb_out             (rgb_out),
        .rgb_valid_out       (rgb_valid),
        .swap_out            (swap_out),
        .repeat_count_out    (rep_out)
    );

    typedef struct {
        bit          v;
        bit          known;
        logic [23:0] rgb;
    } rd_t;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        v_exp;
        logic [23:0] rgb;
    } vec_t;

    int nchk = 0;
    int nerr = 0;

    // Reference model: which buffer is on screen, whether a finished frame
    // is waiting, repeat count, and a 3-deep queue of expected pixels.
    logic [15:0] mem [2][N];
    bit          wrtn [2][N];
    int          disp;
    bit          pend;
    int          rep;
    bit          swp;
    rd_t         pq[$];
    int          swap_seen;

    function automatic logic [23:0] exp565(input logic [15:0] p);
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        rd_t e;
        int  ra;
        bit  acc;
        bit  fire_last;
        acc = wr_valid && !pend;
        e.v = (hc < 11'd1280) && (vc < 10'd720);
        e.known = 1'b1;
        e.rgb = 24'h000000;
        if (e.v) begin
            ra = int'(vc >> 2) * W + int'(hc >> 2);
            e.known = wrtn[disp][ra];
            e.rgb = exp565(mem[disp][ra]);
        end
        pq.push_back(e);
        if (acc && int'(wr_addr) < N) begin
            mem[1-disp][int'(wr_addr)] = wr_pix;
            wrtn[1-disp][int'(wr_addr)] = 1'b1;
        end
        fire_last = acc && wr_last;
        swp = 1'b0;
        if (pend) begin
            if (vlast) swp = 1'b1;
        end else if (fire_last) begin
            if (vlast) swp = 1'b1;
            else pend = 1'b1;
        end else if (vlast && rep < 255) begin
            rep++;
        end
        if (swp) begin
            disp = 1 - disp;
            pend = 1'b0;
            rep = 0;
        end
        @(posedge clk);
        #1;
        e = pq.pop_front();
        chk("wr_ready", wr_ready, !pend);
        chk("swap_out", swap_out, swp);
        chk("repeat", rep_out, rep);
        chk("rgb_valid", rgb_valid, e.v);
        if (e.known) chk("rgb", rgb_out, e.rgb);
        if (swap_out) swap_seen++;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        vlast = 1'b0;
        wr_addr = '0;
        wr_pix = '0;
        hc = 11'd2000;
        vc = 10'd0;
    endtask

    task automatic apply_reset(input int cyc, input bit chk_async);
        idle();
        rst_n = 1'b0;
        #1;
        if (chk_async) begin
            chk("async_ready", wr_ready, 1);
            chk("async_valid", rgb_valid, 0);
            chk("async_rgb", rgb_out, 0);
            chk("async_swap", swap_out, 0);
            chk("async_repeat", rep_out, 0);
        end
        repeat (cyc) @(posedge clk);
        #1;
        chk("rst_ready", wr_ready, 1);
        chk("rst_valid", rgb_valid, 0);
        chk("rst_rgb", rgb_out, 0);
        chk("rst_swap", swap_out, 0);
        chk("rst_repeat", rep_out, 0);
        rst_n = 1'b1;
        pend = 1'b0;
        disp = 1;
        rep = 0;
        swp = 1'b0;
        pq.delete();
        pq.push_back('{v: 1'b0, known: 1'b1, rgb: 24'h0});
        pq.push_back('{v: 1'b0, known: 1'b1, rgb: 24'h0});
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        int          s0;
        logic [15:0] pix0;

        tbl[0] = '{h: 11'd5,    v: 10'd9,   v_exp: 1'b1, rgb: 24'h005008};
        tbl[1] = '{h: 11'd0,    v: 10'd0,   v_exp: 1'b1, rgb: 24'h000000};
        tbl[2] = '{h: 11'd1279, v: 10'd719, v_exp: 1'b1, rgb: 24'hE01CF8};
        tbl[3] = '{h: 11'd1280, v: 10'd0,   v_exp: 1'b0, rgb: 24'h000000};
        tbl[4] = '{h: 11'd0,    v: 10'd720, v_exp: 1'b0, rgb: 24'h000000};
        tbl[5] = '{h: 11'd4,    v: 10'd4,   v_exp: 1'b1, rgb: 24'h002808};
        tbl[6] = '{h: 11'd3,    v: 10'd3,   v_exp: 1'b1, rgb: 24'h000000};
        tbl[7] = '{h: 11'd1023, v: 10'd400, v_exp: 1'b1, rgb: 24'h78BCF8};

        rst_n = 1'b1;
        idle();
        #2;
        apply_reset(3, 1'b0);

        // Fill buffer 0 with pixel = address.
        swap_seen = 0;
        for (int a = 0; a < N; a++) begin
            wr_valid = 1'b1;
            wr_addr = a[15:0];
            wr_pix = a[15:0];
            wr_last = (a == N - 1);
            hc = 11'($urandom_range(0, 1400));
            vc = 10'($urandom_range(0, 760));
            tick();
        end
        wr_addr = 16'd0;
        wr_pix = 16'hDEAD;
        wr_last = 1'b1;
        hc = 11'd2000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_ready", wr_ready, 0);
        end
        idle();
        vlast = 1'b1;
        tick();
        idle();
        tick();
        tick();
        chk("swap_once", swap_seen, 1);
        chk("rep_after_swap", rep_out, 0);
        chk("ready_after_swap", wr_ready, 1);

        for (int i = 0; i < 8; i++) begin
            idle();
            hc = tbl[i].h;
            vc = tbl[i].v;
            tick();
            idle();
            tick();
            tick();
            chk("tbl_valid", rgb_valid, tbl[i].v_exp);
            chk("tbl_rgb", rgb_out, tbl[i].rgb);
        end

        // Three frames with no writer: front frame repeats.
        s0 = swap_seen;
        for (int i = 0; i < 3; i++) begin
            idle();
            vlast = 1'b1;
            tick();
            idle();
            tick();
        end
        chk("repeat3", rep_out, 3);
        chk("no_swap", swap_seen, s0);
        hc = tbl[0].h;
        vc = tbl[0].v;
        tick();
        idle();
        tick();
        tick();
        chk("repeat_hold_rgb", rgb_out, tbl[0].rgb);

        vlast = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        idle();
        tick();
        chk("repeat_sat", rep_out, 255);

        // Buffer 1 partial frame; last write coincides with frame end.
        pix0 = 16'h5A3C;
        for (int a = 0; a < 64; a++) begin
            wr_valid = 1'b1;
            wr_addr = a[15:0];
            wr_pix = (a == 0) ? pix0 : 16'($urandom);
            if (a == 20) begin
                wr_addr = 16'd57600;
                wr_pix = 16'hFFFF;
            end
            wr_last = (a == 63);
            vlast = (a == 63);
            tick();
        end
        chk("same_swap", swap_out, 1);
        chk("same_ready", wr_ready, 1);
        chk("same_repeat", rep_out, 0);
        idle();
        tick();
        chk("fill_ready", wr_ready, 1);
        hc = 11'd0;
        vc = 10'd0;
        tick();
        idle();
        tick();
        tick();
        chk("oor_addr0", rgb_out, exp565(pix0));

        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                wr_addr = 16'($urandom_range(N, 65535));
            else
                wr_addr = 16'($urandom_range(0, 2047));
            wr_pix = 16'($urandom);
            wr_last = ($urandom_range(0, 199) == 0);
            vlast = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) begin
                hc = 11'($urandom_range(0, 1400));
                vc = 10'($urandom_range(0, 760));
            end else begin
                hc = 11'($urandom_range(0, 1279));
                vc = 10'($urandom_range(0, 27));
            end
            tick();
        end

        // Park a finished frame, keep reads active, then reset mid-flight.
        idle();
        wr_valid = 1'b1;
        wr_addr = 16'd7;
        wr_last = 1'b1;
        hc = 11'd40;
        vc = 10'd8;
        tick();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_ready", wr_ready, 0);
        chk("pre_rst_valid", rgb_valid, 1);
        apply_reset(1, 1'b1);

        s0 = swap_seen;
        vlast = 1'b1;
        tick();
        idle();
        tick();
        chk("post_rst_noswap", swap_seen, s0);
        chk("post_rst_repeat", rep_out, 1);
        for (int a = 0; a < 4; a++) begin
            wr_valid = 1'b1;
            wr_addr = a[15:0];
            wr_pix = 16'h1234 + 16'(a * 16'h1111);
            wr_last = (a == 3);
            tick();
        end
        idle();
        tick();
        vlast = 1'b1;
        tick();
        idle();
        tick();
        chk("post_rst_swap", swap_seen, s0 + 1);
        for (int a = 0; a < 4; a++) begin
            hc = 11'(a * 4);
            vc = 10'd0;
            tick();
        end
        idle();
        tick();
        tick();
        hc = 11'd0;
        vc = 10'd0;
        tick();
        idle();
        tick();
        tick();
        chk("post_rst_buf0", rgb_out, exp565(16'h1234));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/frame_buffer_dual.md
Name: frame_buffer_dual

Overview:
Parametrised double-buffered frame store between the ray-cast pixel writer (DDA/flattening stage) and video_sig_gen.
- The writer fills the back buffer at SCREEN resolution.
- The front buffer is read out, upscaled by 2^SCALE_SHIFT, as RGB888 with an aligned valid.
- Buffers swap only at a video frame boundary and only once the back frame is complete. If the writer is late, the front frame repeats; the writer is stalled while a completed frame waits to swap.

Parameters:
PIXEL_WIDTH, 16, stored pixel width; RGB565 packing required when 16.
SCREEN_WIDTH, 320, stored frame width in pixels.
SCREEN_HEIGHT, 180, stored frame height in pixels.
SCALE_SHIFT, 2, display upscale is 2^SCALE_SHIFT in each axis.
FULL_SCREEN_WIDTH, 1280, active display width; must equal SCREEN_WIDTH<<SCALE_SHIFT.
FULL_SCREEN_HEIGHT, 720, active display height; must equal SCREEN_HEIGHT<<SCALE_SHIFT.
BG_COLOR, 24'h000000, RGB emitted outside the active area.
ADDR_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), buffer address width.

Ports:
pixel_clk_in  in  1  pixel clock, sole clock.
rst_n_in  in  1  asynchronous active-low reset.
hcount_in  in  11  from video_sig_gen.
vcount_in  in  10  from video_sig_gen.
video_last_pixel_in  in  1  1-cycle pulse on the final active pixel of a video frame.
wr_valid_in  in  1  writer pixel valid.
wr_addr_in  in  ADDR_W  linear back-buffer address, arbitrary order.
wr_pixel_in  in  PIXEL_WIDTH  pixel data.
wr_last_in  in  1  marks the final pixel of the writer frame; qualified by wr_valid_in && wr_ready_out.
wr_ready_out  out  1  writer may transfer this cycle.
rgb_out  out  24  display pixel.
rgb_valid_out  out  1  rgb_out corresponds to an active-area pixel.
swap_out  out  1  1-cycle pulse on the cycle the buffers exchange.
repeat_count_out  out  8  saturating count of video frames shown without a new back frame.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - front_sel=0, so buffer 1 is displayed and buffer 0 is written.
  - state=FILL.
  - wr_ready_out=1, rgb_out=0, rgb_valid_out=0, swap_out=0, repeat_count_out=0.
  - Buffer contents are untouched by reset.
- Write acceptance: a write happens iff wr_valid_in && wr_ready_out. Writes with wr_addr_in >= SCREEN_WIDTH*SCREEN_HEIGHT are accepted but dropped, with no RAM write. The RAM write enable is never asserted on the front buffer.
- FSM:
  - FILL: wr_ready_out=1. An accepted wr_last_in moves to DONE, unless video_last_pixel_in is high in the same cycle; in that case swap immediately and remain in FILL.
  - DONE: wr_ready_out=0. On video_last_pixel_in, swap and go to FILL.
  - In FILL, video_last_pixel_in without wr_last_in means no swap and repeat_count_out increments, saturating at 255.
- Swap cycle: front_sel toggles on the next edge. swap_out pulses high in the cycle after, aligned with the new front_sel. repeat_count_out clears to 0.
- Read address: ((vcount_in>>SCALE_SHIFT)*SCREEN_WIDTH + (hcount_in>>SCALE_SHIFT)), computed combinationally from the current inputs. It is driven to the front buffer only.
- Read latency: 3 cycles from hcount/vcount to rgb_out/rgb_valid_out; 2 cycles of RAM (HIGH_PERFORMANCE) plus 1 output register.
  - front_sel and the active flag (hcount_in<FULL_SCREEN_WIDTH && vcount_in<FULL_SCREEN_HEIGHT) are delayed through a matching 2-stage pipe.
  - The output mux uses the delayed select, so a swap on the last pixel never corrupts the final 2 in-flight pixels.
- Output format:
  - Inactive: rgb_out=BG_COLOR, rgb_valid_out=0.
  - Active, PIXEL_WIDTH=16: zero-padded {R5,3'b0,G6,2'b0,B5,3'b0}.
  - Active, PIXEL_WIDTH=24: passthrough.
  - Other PIXEL_WIDTH values are a synthesis error.
- Reset mid-frame: the in-flight write frame is abandoned and the pipeline is flushed. The next video frame displays buffer 1 contents, stale or uninitialised.

Decomposition:
- Package fb_pkg:
  - fb_state_t enum (FILL, DONE).
  - rgb565_to_888 function.
  - Default screen constants.
- Sub-module fb_bank: one xilinx_single_port_ram_read_first wrapper with write-enable gating and range check. It is instantiated twice and selected by front_sel.
- FSM, address generation, latency pipe and output mux stay in the top.

Test Plan:
- Reset, then write all 57600 addresses of buffer 0 with pixel=addr[15:0], wr_last on addr 57599, then pulse video_last_pixel_in → swap_out pulses once, wr_ready_out is 0 between wr_last and the swap, and repeat_count_out=0.
- After that swap, drive hcount=5, vcount=9 → 3 cycles later rgb_valid_out=1 and rgb_out equals the 565→888 expansion of 16'd(2*320+1)=16'd641.
- Three video_last_pulses with no writer activity → no swap_out, repeat_count_out=3; the display keeps the prior frame.
- wr_last accepted in the same cycle as video_last_pixel_in → swap next edge, state stays FILL, wr_ready_out stays 1.
- Write to address 57600 with pixel 16'hFFFF → no change to any stored word (readback at address 0 is unchanged); hcount=1280 → rgb_valid_out=0, rgb_out=BG_COLOR.
- Assert rst_n_in low mid-fill for 1 cycle → all outputs reset immediately (asynchronously); after release, writes target buffer 0 and swap requires a fresh wr_last.
